window_collector: RTL and testbench

// - Consumer end of the 3x3 window address stream: receives the 9 pixel values read back from image RAM per window.
// - Assembles each window, accumulates its sum, and presents the result with its linear output address.
// - Sits between the image RAM read port and the filter/writeback stage.
// - One window = 9 consecutive accepted samples, row-major: (r,c) (r,c+1) (r,c+2) (r+1,c) .. (r+2,c+2).

---
 rtl/window_collector_if.sv | 32 +++
 rtl/window_collector.sv | 146 ++++++++++++++
 tb/tb_window_collector.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_collector_if.sv
// window_collector_if
// Stream bundle between the image RAM read port, the window collector and
// the filter/writeback stage.
//   in_valid / in_ready / in_pixel : pixel samples in window slot order
//   out_valid / out_ready          : result handshake
//   out_window                     : 9 slots, slot n at [n*PIX_W +: PIX_W]
//   out_sum                        : unsigned sum of the 9 slots
//   out_addr                       : linear output index of the window
// Modports: slave = the collector, master = the environment driving it.
interface window_collector_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 12
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [PIX_W-1:0]     in_pixel;
  logic                 out_valid;
  logic                 out_ready;
  logic [9*PIX_W-1:0]   out_window;
  logic [PIX_W+3:0]     out_sum;
  logic [ADDR_W-1:0]    out_addr;

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_window, out_sum, out_addr
  );

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_window, out_sum, out_addr
  );
endinterface

// File: rtl/window_collector.sv
// window_collector
// Consumer end of the 3x3 window address stream. Collects the 9 pixel
// values read back from image RAM for each window (row-major order),
// accumulates their sum and presents window, sum and linear output address
// to the filter/writeback stage.
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous reset, active-high
//   start  : begin a frame; only honoured in IDLE or DONE
//   bus    : window_collector_if.slave (pixel input and result output)
//   done   : frame complete, sticky until the next start or rst
module window_collector #(
  parameter int IMG_W  = 50,
  parameter int IMG_H  = 50,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  window_collector_if.slave   bus,
  output logic                done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((IMG_W-2)*(IMG_H-2)-1);
  localparam logic [3:0]        LAST_SLOT = 4'd8;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [3:0]           slot_cnt;
  logic [PIX_W+3:0]     acc;
  logic [9*PIX_W-1:0]   window_q;
  logic [PIX_W+3:0]     sum_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 done_q;
  logic                 in_ready;
  logic                 out_valid;

  logic                 accept;
  logic                 transfer;
  logic                 frame_start;
  logic [PIX_W+3:0]     pix_ext;

  // Handshake qualifiers are derived from the state register directly so
  // they do not depend on the combinational outputs of the FSM process.
  assign accept      = bus.in_valid && (state == COLLECT);
  assign transfer    = bus.out_ready && (state == HOLD);
  assign frame_start = start && ((state == IDLE) || (state == DONE));
  assign pix_ext     = {4'b0000, bus.in_pixel};

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_window = window_q;
  assign bus.out_sum    = sum_q;
  assign bus.out_addr   = addr_q;
  assign done           = done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs. HOLD is the only state presenting a
  // result, COLLECT the only one taking samples, so the input and output
  // sides never overlap.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        in_ready = 1'b1;
        if (accept && (slot_cnt == LAST_SLOT)) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = (addr_q == LAST_ADDR) ? DONE : COLLECT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Slots are written straight into the output window register;
  // it is only qualified by out_valid, so partial contents during COLLECT
  // are harmless. The final sum includes the 9th sample on the same edge it
  // is accepted, giving a one-cycle result latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      acc      <= '0;
      window_q <= '0;
      sum_q    <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      if (frame_start) begin
        slot_cnt <= '0;
        acc      <= '0;
        addr_q   <= '0;
        done_q   <= 1'b0;
      end

      if (accept) begin
        for (int n = 0; n < 9; n++) begin
          if (slot_cnt == 4'(n)) begin
            window_q[n*PIX_W +: PIX_W] <= bus.in_pixel;
          end
        end
        if (slot_cnt == LAST_SLOT) begin
          sum_q    <= acc + pix_ext;
          acc      <= '0;
          slot_cnt <= '0;
        end else begin
          acc      <= acc + pix_ext;
          slot_cnt <= slot_cnt + 4'd1;
        end
      end

      // The address only advances on a transfer that is not the last one,
      // so it parks on the final index until the next frame start.
      if (transfer) begin
        if (addr_q == LAST_ADDR) begin
          done_q <= 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_collector.sv
// tb_window_collector
// Self-checking bench for window_collector (50x50 image, 8-bit pixels).
// Windows are driven from a vector table and from random data; each
// driven window pushes its expected window/sum/address into a scoreboard
// queue that a monitor pops on every output transfer.
module tb_window_collector;

  localparam int NUM_WIN = 48 * 48;

  logic clk;
  logic rst;
  logic start;
  logic done;

  window_collector_if #(.PIX_W(8), .ADDR_W(12)) bus ();

  window_collector #(
    .IMG_W (50),
    .IMG_H (50),
    .PIX_W (8),
    .ADDR_W(12)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bus  (bus),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] win;
    logic [11:0] sum;
    logic [11:0] addr;
  } exp_t;

  typedef struct {
    logic [8:0][7:0] pix;
    logic [11:0]     sum;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;
  int   exp_addr = 0;

  // Compare one value and report on mismatch.
  task automatic check_output(input string name, input logic [95:0] act,
                              input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  function automatic logic [8:0][7:0] mk9(
    input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
    input logic [7:0] a3, input logic [7:0] a4, input logic [7:0] a5,
    input logic [7:0] a6, input logic [7:0] a7, input logic [7:0] a8);
    logic [8:0][7:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2;
    r[3] = a3; r[4] = a4; r[5] = a5;
    r[6] = a6; r[7] = a7; r[8] = a8;
    return r;
  endfunction

  // Present one sample and hold it until the DUT takes it.
  task automatic apply_stimulus(input logic [7:0] pix);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    bus.in_valid = 1'b1;
    bus.in_pixel = pix;
    while (!got && n < 50) begin
      @(negedge clk);
      got = bus.in_ready;
      step();
      n++;
    end
    bus.in_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", n);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] sample was never accepted");
    end
  endtask

  // Drive a full window, queueing its expected result first. Optional
  // random idle gaps, a start pulse before slot start_at, and a check
  // that out_valid is up one cycle after the 9th accept.
  task automatic send_window(input logic [8:0][7:0] pix, input logic [11:0] exp_sum,
                             input bit gaps, input int start_at, input bit chk_latency);
    exp_t e;
    e.win  = pix;
    e.sum  = exp_sum;
    e.addr = 12'(exp_addr);
    sb.push_back(e);
    exp_addr++;
    for (int i = 0; i < 9; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          bus.in_pixel = 8'($urandom);
          step();
        end
      end
      if (i == start_at) begin
        start = 1'b1;
        step();
        start = 1'b0;
      end
      apply_stimulus(pix[i]);
    end
    if (chk_latency) begin
      @(negedge clk);
      check_output("latency_out_valid", {95'd0, bus.out_valid}, 96'd1);
      step();
    end
  endtask

  task automatic random_window(output logic [8:0][7:0] pix, output logic [11:0] sum);
    int s;
    s = 0;
    for (int i = 0; i < 9; i++) begin
      pix[i] = 8'($urandom_range(0, 255));
      s += int'(pix[i]);
    end
    sum = 12'(s);
  endtask

  // Wait for every queued result to be transferred.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
    end
    step();
  endtask

  // Scoreboard monitor: a transfer happens on the edge after this sample.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got result at addr %0d, expected none", bus.out_addr);
      end else begin
        mon_e = sb.pop_front();
        check_output("sb_out_window", {24'd0, bus.out_window}, {24'd0, mon_e.win});
        check_output("sb_out_sum", {84'd0, bus.out_sum}, {84'd0, mon_e.sum});
        check_output("sb_out_addr", {84'd0, bus.out_addr}, {84'd0, mon_e.addr});
      end
    end
  end

  initial begin
    logic [8:0][7:0] p;
    logic [11:0]     s;

    vecs[0].pix = mk9(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
    vecs[0].sum = 12'd45;
    vecs[1].pix = mk9(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    vecs[1].sum = 12'd2295;
    vecs[2].pix = mk9(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    vecs[2].sum = 12'd0;
    vecs[3].pix = mk9(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90);
    vecs[3].sum = 12'd450;
    vecs[4].pix = mk9(8'd200, 8'd0, 8'd200, 8'd0, 8'd200, 8'd0, 8'd200, 8'd0, 8'd200);
    vecs[4].sum = 12'd1000;
    vecs[5].pix = mk9(8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd128);
    vecs[5].sum = 12'd129;

    rst           = 1'b1;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = 8'd0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check_output("rst_in_ready", {95'd0, bus.in_ready}, 96'd0);
    check_output("rst_out_valid", {95'd0, bus.out_valid}, 96'd0);
    check_output("rst_out_window", {24'd0, bus.out_window}, 96'd0);
    check_output("rst_out_sum", {84'd0, bus.out_sum}, 96'd0);
    check_output("rst_out_addr", {84'd0, bus.out_addr}, 96'd0);
    check_output("rst_done", {95'd0, done}, 96'd0);

    // IDLE ignores samples.
    step();
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'd99;
    step();
    bus.in_valid = 1'b0;

    bus.out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    check_output("start_in_ready", {95'd0, bus.in_ready}, 96'd1);
    step();

    // Vector table, back-to-back windows.
    for (int v = 0; v < 6; v++) begin
      send_window(vecs[v].pix, vecs[v].sum, 1'b0, -1, 1'b1);
    end

    // Output stall with the producer pushing and start pulsed: nothing moves.
    bus.out_ready = 1'b0;
    p = mk9(8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19);
    send_window(p, 12'd135, 1'b0, -1, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'd77;
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_output("stall_in_ready", {95'd0, bus.in_ready}, 96'd0);
      check_output("stall_out_valid", {95'd0, bus.out_valid}, 96'd1);
      check_output("stall_out_window", {24'd0, bus.out_window}, {24'd0, p});
      check_output("stall_out_sum", {84'd0, bus.out_sum}, 96'd135);
      check_output("stall_out_addr", {84'd0, bus.out_addr}, 96'd6);
      step();
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
    p = mk9(8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
    send_window(p, 12'd29, 1'b0, -1, 1'b1);

    // Random idle gaps with garbage on in_pixel.
    for (int w = 0; w < 4; w++) begin
      random_window(p, s);
      send_window(p, s, 1'b1, -1, 1'b0);
    end

    // start pulsed mid-COLLECT is ignored.
    random_window(p, s);
    send_window(p, s, 1'b0, 4, 1'b1);

    // Rest of the frame.
    while (exp_addr < NUM_WIN) begin
      random_window(p, s);
      send_window(p, s, 1'b0, -1, 1'b0);
    end
    drain();
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output("frame_done", {95'd0, done}, 96'd1);
      check_output("frame_in_ready", {95'd0, bus.in_ready}, 96'd0);
      check_output("frame_out_valid", {95'd0, bus.out_valid}, 96'd0);
      check_output("frame_last_addr", {84'd0, bus.out_addr}, 96'd2303);
      step();
    end
    bus.in_valid = 1'b0;

    // Restart from DONE.
    start = 1'b1;
    step();
    start = 1'b0;
    exp_addr = 0;
    @(negedge clk);
    check_output("restart_done", {95'd0, done}, 96'd0);
    check_output("restart_out_addr", {84'd0, bus.out_addr}, 96'd0);
    check_output("restart_in_ready", {95'd0, bus.in_ready}, 96'd1);
    step();

    // Reset after 4 samples discards the partial window.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(8'(8'd100 + 8'(i)));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_output("midrst_in_ready", {95'd0, bus.in_ready}, 96'd0);
    check_output("midrst_out_valid", {95'd0, bus.out_valid}, 96'd0);
    check_output("midrst_out_window", {24'd0, bus.out_window}, 96'd0);
    check_output("midrst_out_sum", {84'd0, bus.out_sum}, 96'd0);
    check_output("midrst_out_addr", {84'd0, bus.out_addr}, 96'd0);
    check_output("midrst_done", {95'd0, done}, 96'd0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_addr = 0;
    p = mk9(8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1);
    send_window(p, 12'd45, 1'b0, -1, 1'b1);
    drain();

    finish_run();
  end

  // Global guard against a stuck run.
  initial begin
    #2000000;
    checks++;
    errors++;
    $display("[TB] FAIL global_timeout: got still running, expected finished");
    finish_run();
  end

endmodule
